sd_block_fifo: RTL and testbench
================================

# sd_block_fifo

Byte FIFO that buffers the incoming capture stream and feeds the SD card writer stage one 512-byte block at a time. The producer pushes bytes at up to one per clock. The SD writer watches the fill level, then pops a full block on consecutive clocks. The FIFO is first-word-fall-through, so the popped byte is read from the data port in the same cycle the pop is asserted. Overflow and underflow are sticky error flags for debug LEDs.

## Interface
- DATA_WIDTH, 8, byte width of each entry.
- ADDR_WIDTH, 10, log2 of the depth (1024 entries).
- BLOCK_BYTES, 512, bytes per SD block; used only by the block-ready watermark.
- i_s_clk  in  1  system/SPI clock; all state changes on its rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_push  in  1  write strobe from the producer.
- i_8_data_in  in  DATA_WIDTH  byte to write, sampled when i_push=1.
- i_pop  in  1  read strobe from the SD writer.
- o_8_data_out  out  DATA_WIDTH  head entry (FWFT); valid whenever o_empty=0.
- o_data_count  out  ADDR_WIDTH+1  number of stored entries, 0..1024.
- o_full  out  1  count == 1024.
- o_empty  out  1  count == 0.
- o_overflow  out  1  sticky: a push was rejected.
- o_underflow  out  1  sticky: a pop was rejected.
- o_block_ready  out  1  count >= BLOCK_BYTES; present only with the watermark macro.

## Operation
- Storage is a 1024x8 array with a write pointer and a read pointer, each ADDR_WIDTH bits. Pointers wrap naturally from 1023 to 0.
- The count is a separate ADDR_WIDTH+1 register, not derived from the pointers. o_full and o_empty are decoded from the count.
- Accepted push (i_push & (!o_full | i_pop)): write mem[wr_ptr], then wr_ptr+1.
- Accepted pop (i_pop & !o_empty): rd_ptr+1.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Push while full with no pop is ignored. It sets o_overflow and leaves the array and pointers unchanged.
- Push while full with a pop in the same cycle is accepted, and the count stays at 1024.
- Pop while empty is ignored and sets o_underflow. This holds even if a push occurs the same cycle; that push is still accepted.
- o_8_data_out = mem[rd_ptr] as an asynchronous read. Its value is don't-care while empty.
- o_overflow and o_underflow clear only on i_reset.
- Reset mid-operation discards all contents immediately. Array contents need not be cleared.

## Timing
- Reset values:
  - o_data_count=0, o_empty=1, o_full=0.
  - o_overflow=0, o_underflow=0, o_block_ready=0.
  - o_8_data_out is don't-care.
- Push-to-visible latency is 1 clock. A byte pushed at edge N appears on o_8_data_out, with o_empty=0, right after edge N.
- Pop consumes the currently presented byte at edge N. The next byte is presented right after edge N.
- A consumer asserting i_pop for 512 consecutive cycles receives 512 consecutive bytes, one per cycle, with no bubbles, provided the count was >= 512 at the start.
- All flags are registered or decoded from registered count: no combinational path from i_push or i_pop to any status output.

## Configuration
- SD_FIFO_BLOCK_READY_EN
  - Defined: o_block_ready exists and is registered, equal to (count >= BLOCK_BYTES), updated with the count.
  - Undefined: the port and its comparator are removed. The consumer compares o_data_count itself.

## Structure
- Shared package sd_pkg holds:
  - SD_BLOCK_BYTES = 512.
  - SD_FIFO_ADDR_WIDTH = 10.
  - The count width constant.
  - A byte typedef sd_byte_t.
- The SD writer stage uses the same package constants.
- One sub-module: sd_fifo_ram, a 1024x8 RAM with a synchronous write port and an asynchronous read port, so it maps to distributed RAM. Pointer, count and flag logic stay in sd_block_fifo.

## Test plan
- Reset, then push 0x00..0x04 on 5 cycles:
  - count=5, o_empty=0, o_8_data_out=0x00.
  - Pop 5 times → bytes 0x00..0x04 in order, then o_empty=1, count=0.
- Push 1024 bytes (i mod 256):
  - o_full=1, count=1024, o_block_ready=1.
  - An extra push → o_overflow=1, count stays 1024, head still 0x00.
- With the FIFO full, push 0xAA and pop simultaneously:
  - count stays 1024, popped byte 0x00, new head 0x01.
  - 0xAA is read last after draining.
- Empty FIFO:
  - Pop alone → o_underflow=1, count=0.
  - Push 0x55 with simultaneous pop → count=1, head 0x55.
- Wrap-around: push 700, pop 700, then push 600 (wr_ptr wraps), then pop 512 back-to-back:
  - data continuous, no bubble, count=88.
  - o_block_ready falls on the cycle count drops to 511.
- Assert i_reset mid-burst at count=300:
  - all outputs return to reset values at once.
  - A subsequent push/pop of 0x11 returns 0x11.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared constants and types for the SD capture path (FIFO and SD writer).
// Holds block size, FIFO depth/count widths and the byte type.
package sd_pkg;

    localparam int SD_BYTE_WIDTH       = 8;
    localparam int SD_BLOCK_BYTES      = 512;
    localparam int SD_FIFO_ADDR_WIDTH  = 10;
    localparam int SD_FIFO_COUNT_WIDTH = SD_FIFO_ADDR_WIDTH + 1;

    typedef logic [SD_BYTE_WIDTH-1:0] sd_byte_t;

endpackage

// File: rtl/sd_fifo_ram.sv
// Storage array for sd_block_fifo: synchronous write, asynchronous read.
// Ports: clk, we, waddr, wdata (write side); raddr -> rdata (comb read).
module sd_fifo_ram
    import sd_pkg::*;
#(
    parameter int DATA_WIDTH = SD_BYTE_WIDTH,
    parameter int ADDR_WIDTH = SD_FIFO_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sd_block_fifo.sv
// First-word-fall-through byte FIFO feeding the SD writer one block at a time.
// Ports: i_s_clk, i_reset (async, high), i_push/i_8_data_in, i_pop,
//        o_8_data_out (head), o_data_count, o_full, o_empty,
//        o_overflow/o_underflow (sticky), o_block_ready.
// Macro SD_FIFO_BLOCK_READY_EN adds the registered o_block_ready watermark.
module sd_block_fifo
    import sd_pkg::*;
#(
    parameter int DATA_WIDTH  = SD_BYTE_WIDTH,
    parameter int ADDR_WIDTH  = SD_FIFO_ADDR_WIDTH
`ifdef SD_FIFO_BLOCK_READY_EN
    ,
    parameter int BLOCK_BYTES = SD_BLOCK_BYTES
`endif
) (
    input  logic                  i_s_clk,
    input  logic                  i_reset,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_8_data_in,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_8_data_out,
    output logic [ADDR_WIDTH:0]   o_data_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic                  o_underflow
`ifdef SD_FIFO_BLOCK_READY_EN
    ,
    output logic                  o_block_ready
`endif
);

    localparam int CW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_next;
    logic                  push_ok;
    logic                  pop_ok;

    // count never exceeds 2**ADDR_WIDTH, so its MSB alone marks full
    assign o_full       = count[ADDR_WIDTH];
    assign o_empty      = (count == '0);
    assign o_data_count = count;

    // a pop frees the slot a push into a full FIFO needs
    always_comb begin
        push_ok = i_push & (~o_full | i_pop);
        pop_ok  = i_pop & ~o_empty;
    end

    always_comb begin
        count_next = count;
        unique case ({push_ok, pop_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_s_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            count <= count_next;
            if (i_push & ~push_ok) begin
                o_overflow <= 1'b1;
            end
            if (i_pop & ~pop_ok) begin
                o_underflow <= 1'b1;
            end
        end
    end

`ifdef SD_FIFO_BLOCK_READY_EN
    localparam logic [CW-1:0] BLK = CW'(BLOCK_BYTES);

    // registered from count_next so it tracks the count register exactly
    always_ff @(posedge i_s_clk or posedge i_reset) begin
        if (i_reset) begin
            o_block_ready <= 1'b0;
        end else begin
            o_block_ready <= (count_next >= BLK);
        end
    end
`endif

    sd_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (i_s_clk),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (i_8_data_in),
        .raddr (rd_ptr),
        .rdata (o_8_data_out)
    );

endmodule

// File: tb/tb_sd_block_fifo.sv
// Self-checking bench for sd_block_fifo: queue reference model, per-cycle
// comparison, directed scenarios plus randomized push/pop traffic.
module tb_sd_block_fifo;
    import sd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    sd_byte_t    din = '0;
    sd_byte_t    dout;
    logic [10:0] cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
`ifdef SD_FIFO_BLOCK_READY_EN
    logic        blk;
`endif

    int vectors = 0;
    int miscompares = 0;

    sd_block_fifo dut (
        .i_s_clk      (clk),
        .i_reset      (rst),
        .i_push       (push),
        .i_8_data_in  (din),
        .i_pop        (pop),
        .o_8_data_out (dout),
        .o_data_count (cnt),
        .o_full       (full),
        .o_empty      (empty),
        .o_overflow   (ovf),
        .o_underflow  (unf)
`ifdef SD_FIFO_BLOCK_READY_EN
        ,
        .o_block_ready(blk)
`endif
    );

    always #5 clk = ~clk;

    // reference model: a queue of stored bytes plus two sticky bits
    sd_byte_t q[$];
    bit       m_ovf;
    bit       m_unf;
    bit       m_was_empty;
    bit       m_was_full;
    sd_byte_t m_dummy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_was_empty = (q.size() == 0);
            m_was_full  = (q.size() == 1024);
            if (pop) begin
                if (m_was_empty) m_unf = 1'b1;
                else m_dummy = q.pop_front();
            end
            if (push) begin
                if (!m_was_full || pop) q.push_back(din);
                else m_ovf = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        check("count", 32'(cnt), 32'(q.size()));
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == 1024));
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("underflow", 32'(unf), 32'(m_unf));
`ifdef SD_FIFO_BLOCK_READY_EN
        check("block_ready", 32'(blk), 32'(q.size() >= 512));
`endif
        if (q.size() > 0) check("data_out", 32'(dout), 32'(q[0]));
    end

    // drive at negedge+1, let one rising edge pass, return at negedge+1
    task automatic step(input bit p, input sd_byte_t d, input bit r);
        push = p;
        din  = d;
        pop  = r;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_count", 32'(cnt), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_unf", 32'(unf), 32'd0);
`ifdef SD_FIFO_BLOCK_READY_EN
        check("rst_blk", 32'(blk), 32'd0);
`endif
        rst = 1'b0;
        step(0, 8'h00, 0);

        // five bytes in, five out
        for (int i = 0; i < 5; i++) step(1, 8'(i), 0);
        step(0, 8'h00, 0);
        check("five_count", 32'(cnt), 32'd5);
        check("five_empty", 32'(empty), 32'd0);
        check("five_head", 32'(dout), 32'h00);
        for (int i = 0; i < 5; i++) begin
            check("five_pop", 32'(dout), 32'(i));
            step(0, 8'h00, 1);
        end
        check("five_drained", 32'(empty), 32'd1);
        check("five_cnt0", 32'(cnt), 32'd0);

        // fill completely, then overflow
        for (int i = 0; i < 1024; i++) step(1, 8'(i % 256), 0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(cnt), 32'd1024);
`ifdef SD_FIFO_BLOCK_READY_EN
        check("fill_blk", 32'(blk), 32'd1);
`endif
        step(1, 8'hFF, 0);
        check("ovf_flag", 32'(ovf), 32'd1);
        check("ovf_count", 32'(cnt), 32'd1024);
        check("ovf_head", 32'(dout), 32'h00);

        // push + pop while full
        check("fullpp_popped", 32'(dout), 32'h00);
        step(1, 8'hAA, 1);
        check("fullpp_count", 32'(cnt), 32'd1024);
        check("fullpp_head", 32'(dout), 32'h01);
        for (int i = 0; i < 1023; i++) step(0, 8'h00, 1);
        check("aa_last", 32'(dout), 32'hAA);
        check("aa_count", 32'(cnt), 32'd1);
        step(0, 8'h00, 1);

        // underflow, then push+pop on empty
        step(0, 8'h00, 1);
        check("unf_flag", 32'(unf), 32'd1);
        check("unf_count", 32'(cnt), 32'd0);
        step(1, 8'h55, 1);
        check("emptypp_count", 32'(cnt), 32'd1);
        check("emptypp_head", 32'(dout), 32'h55);
        step(0, 8'h00, 1);

        // pointer wrap and a back-to-back block read
        for (int i = 0; i < 700; i++) step(1, 8'($urandom), 0);
        for (int i = 0; i < 700; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 600; i++) step(1, 8'($urandom), 0);
        for (int i = 0; i < 512; i++) begin
            check("burst_nobubble", 32'(empty), 32'd0);
`ifdef SD_FIFO_BLOCK_READY_EN
            if (i == 88) check("blk_before_fall", 32'(blk), 32'd1);
            if (i == 89) check("blk_fall", 32'(blk), 32'd0);
`endif
            step(0, 8'h00, 1);
        end
        check("burst_count", 32'(cnt), 32'd88);

        // async reset mid-burst with sticky flags set
        for (int i = 0; i < 212; i++) step(1, 8'($urandom), 0);
        check("pre_rst_count", 32'(cnt), 32'd300);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(cnt), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        check("mid_rst_unf", 32'(unf), 32'd0);
`ifdef SD_FIFO_BLOCK_READY_EN
        check("mid_rst_blk", 32'(blk), 32'd0);
`endif
        @(negedge clk);
        #1;
        rst = 1'b0;
        step(1, 8'h11, 0);
        check("post_rst_data", 32'(dout), 32'h11);
        step(0, 8'h00, 1);
        check("post_rst_empty", 32'(empty), 32'd1);

        // randomized traffic with phases biased toward full and empty
        for (int ph = 0; ph < 16; ph++) begin
            int pp;
            int rp;
            unique case (ph % 3)
                0: begin pp = 90; rp = 30; end
                1: begin pp = 30; rp = 90; end
                default: begin pp = 60; rp = 60; end
            endcase
            for (int i = 0; i < 300; i++) begin
                step($urandom_range(99) < pp, 8'($urandom),
                     $urandom_range(99) < rp);
            end
        end

        step(0, 8'h00, 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
